// File: rtl/bus_transfer_engine.sv
// Sequenced unit-to-unit bus transfer engine.
// It reads one word from a source unit and delivers it, with a command, to a destination unit.
module bus_transfer_engine #(
  parameter int NUM_UNITS      = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int CMD_WIDTH      = 4,
  parameter int ID_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            i_Clk,
  input  logic                            i_Reset,
  input  logic                            i_xfer_valid,
  output logic                            o_xfer_ready,
  input  logic [ID_WIDTH-1:0]             i_src_id,
  input  logic [ID_WIDTH-1:0]             i_dst_id,
  input  logic [CMD_WIDTH-1:0]            i_src_cmd,
  input  logic [CMD_WIDTH-1:0]            i_dst_cmd,
  output logic [NUM_UNITS*CMD_WIDTH-1:0]  o_unit_cmd,
  output logic [NUM_UNITS-1:0]            o_unit_valid,
  output logic [DATA_WIDTH-1:0]           o_unit_data,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] i_unit_data,
  input  logic [NUM_UNITS-1:0]            i_unit_valid,
  output logic                            o_busy,
  output logic                            o_xfer_done,
  output logic                            o_xfer_error,
  output logic [1:0]                      o_err_code
);

  localparam int SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ID_WIDTH:0]  NUM_UNITS_ID = (ID_WIDTH + 1)'(NUM_UNITS);
  localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_BAD_ID  = 2'd1;
  localparam logic [1:0] ERR_SAME_ID = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DELIVER
  } state_t;

  state_t                 state_q;
  logic [ID_WIDTH-1:0]    src_q;
  logic [ID_WIDTH-1:0]    dst_q;
  logic [CMD_WIDTH-1:0]   scmd_q;
  logic [CMD_WIDTH-1:0]   dcmd_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   done_q;
  logic                   err_q;
  logic [1:0]             code_q;

  logic [SEL_W-1:0]       src_sel;
  logic [SEL_W-1:0]       dst_sel;
  logic                   bad_id;
  logic                   same_id;
  logic [DATA_WIDTH-1:0]  unit_rdata [NUM_UNITS];

  assign src_sel = src_q[SEL_W-1:0];
  assign dst_sel = dst_q[SEL_W-1:0];

  // Bad id takes priority over src==dst when both apply.
  assign bad_id  = ({1'b0, i_src_id} >= NUM_UNITS_ID) || ({1'b0, i_dst_id} >= NUM_UNITS_ID);
  assign same_id = (i_src_id == i_dst_id);

  always_comb begin
    for (int k = 0; k < NUM_UNITS; k++) begin
      unit_rdata[k] = i_unit_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign o_xfer_ready = (state_q == ST_IDLE) && !i_Reset;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_xfer_done  = done_q;
  assign o_xfer_error = err_q;
  assign o_err_code   = code_q;
  assign o_unit_data  = data_q;

  always_comb begin
    o_unit_cmd   = '0;
    o_unit_valid = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (state_q == ST_FETCH && src_sel == SEL_W'(k)) begin
        o_unit_cmd[k*CMD_WIDTH +: CMD_WIDTH] = scmd_q;
      end
      if (state_q == ST_DELIVER && dst_sel == SEL_W'(k)) begin
        o_unit_cmd[k*CMD_WIDTH +: CMD_WIDTH] = dcmd_q;
        o_unit_valid[k]                      = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      scmd_q  <= '0;
      dcmd_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_xfer_valid) begin
            src_q  <= i_src_id;
            dst_q  <= i_dst_id;
            scmd_q <= i_src_cmd;
            dcmd_q <= i_dst_cmd;
            if (bad_id) begin
              err_q  <= 1'b1;
              code_q <= ERR_BAD_ID;
            end else if (same_id) begin
              err_q  <= 1'b1;
              code_q <= ERR_SAME_ID;
            end else begin
              state_q <= ST_FETCH;
              cnt_q   <= '0;
            end
          end
        end
        ST_FETCH: begin
          // A valid in the last allowed cycle still completes the transfer.
          if (i_unit_valid[src_sel]) begin
            data_q  <= unit_rdata[src_sel];
            state_q <= ST_DELIVER;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
            code_q  <= ERR_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DELIVER: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_transfer_engine.sv
// Scoreboard bench for bus_transfer_engine: expected deliveries and completions are queued
// at request time and retired by a negedge monitor; directed checks pin cycle timing.
module tb_bus_transfer_engine;

  localparam int NU = 4;
  localparam int DW = 16;
  localparam int CW = 4;
  localparam int IW = 4;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              xv;
  logic [IW-1:0]     sid, did;
  logic [CW-1:0]     scmd, dcmd;
  logic              ready;
  logic [NU*CW-1:0]  o_unit_cmd;
  logic [NU-1:0]     o_unit_valid;
  logic [DW-1:0]     o_unit_data;
  logic [NU*DW-1:0]  udata;
  logic [NU-1:0]     uvld;
  logic              busy, done, err;
  logic [1:0]        code;

  always #5 clk = ~clk;

  bus_transfer_engine #(
    .NUM_UNITS(NU), .DATA_WIDTH(DW), .CMD_WIDTH(CW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_Clk(clk),
    .i_Reset(rst),
    .i_xfer_valid(xv),
    .o_xfer_ready(ready),
    .i_src_id(sid),
    .i_dst_id(did),
    .i_src_cmd(scmd),
    .i_dst_cmd(dcmd),
    .o_unit_cmd(o_unit_cmd),
    .o_unit_valid(o_unit_valid),
    .o_unit_data(o_unit_data),
    .i_unit_data(udata),
    .i_unit_valid(uvld),
    .o_busy(busy),
    .o_xfer_done(done),
    .o_xfer_error(err),
    .o_err_code(code)
  );

  typedef struct {
    logic        err;
    logic [1:0]  code;
    logic [3:0]  dst;
    logic [3:0]  dcmd;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic req(input logic [3:0] s, input logic [3:0] d,
                     input logic [3:0] sc, input logic [3:0] dc);
    xv = 1'b1; sid = s; did = d; scmd = sc; dcmd = dc;
    cyc();
    xv = 1'b0;
  endtask

  task automatic push(input logic e_err, input logic [1:0] e_code, input logic [3:0] e_dst,
                      input logic [3:0] e_dcmd, input logic [15:0] e_data);
    exp_t e;
    e.err = e_err; e.code = e_code; e.dst = e_dst; e.dcmd = e_dcmd; e.data = e_data;
    exp_q.push_back(e);
  endtask

  task automatic set_unit(input int k, input logic v, input logic [15:0] d);
    uvld[k] = v;
    udata[k*DW +: DW] = d;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (o_unit_valid != '0) begin
        if (exp_q.size() == 0) chk("sb_deliver_unexpected", 64'(o_unit_valid), 64'd0);
        else begin
          chk("sb_dst_valid", 64'(o_unit_valid), 64'(4'b0001 << exp_q[0].dst));
          chk("sb_data", 64'(o_unit_data), 64'(exp_q[0].data));
          chk("sb_dst_cmd", 64'(o_unit_cmd), 64'(16'(exp_q[0].dcmd) << (exp_q[0].dst * 4)));
        end
      end
      if (done || err) begin
        chk("done_err_exclusive", 64'(done & err), 64'd0);
        if (exp_q.size() == 0) chk("sb_unexpected_pulse", 64'({done, err}), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("sb_err_flag", 64'(err), 64'(e.err));
          if (e.err) chk("sb_err_code", 64'(code), 64'(e.code));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    xv = 0; sid = 0; did = 0; scmd = 0; dcmd = 0; uvld = 0; udata = 0; rst = 1;
    repeat (2) cyc();
    chk("rst_outputs", 64'({ready, busy, done, err, code, o_unit_cmd, o_unit_valid, o_unit_data}), 64'd0);
    rst = 0;
    cyc();
    chk("ready_after_rst", 64'(ready), 64'd1);

    // Immediate source valid: FETCH at cycle 1, DELIVER at 2, done at 3
    set_unit(1, 1'b1, 16'hBEEF);
    push(0, 0, 0, 5, 16'hBEEF);
    req(1, 0, 3, 5);
    chk("t1_fetch_cmd", 64'(o_unit_cmd), 64'h0030);
    chk("t1_fetch_valid", 64'(o_unit_valid), 64'd0);
    cyc();
    chk("t1_dlv_valid", 64'(o_unit_valid), 64'b0001);
    chk("t1_dlv_cmd", 64'(o_unit_cmd), 64'h0005);
    chk("t1_dlv_data", 64'(o_unit_data), 64'hBEEF);
    set_unit(1, 1'b0, 16'h0);
    cyc();
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_ready", 64'(ready), 64'd1);
    chk("t1_err", 64'(err), 64'd0);
    cyc();
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_data_hold", 64'(o_unit_data), 64'hBEEF);

    // Delayed source valid, with a distractor valid on another unit
    set_unit(0, 1'b1, 16'hDEAD);
    push(0, 0, 3, 9, 16'h1234);
    req(2, 3, 2, 9);
    for (int c = 1; c < 5; c++) begin
      chk("t2_fetch_cmd", 64'(o_unit_cmd), 64'h0200);
      cyc();
    end
    set_unit(2, 1'b1, 16'h1234);
    cyc();
    chk("t2_dlv_valid", 64'(o_unit_valid), 64'b1000);
    chk("t2_dlv_cmd", 64'(o_unit_cmd), 64'h9000);
    chk("t2_dlv_data", 64'(o_unit_data), 64'h1234);
    set_unit(2, 1'b0, 16'h0);
    set_unit(0, 1'b0, 16'h0);
    cyc();
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_err", 64'(err), 64'd0);

    // Timeout after TO fetch cycles
    push(1, 3, 0, 0, 16'h0);
    req(1, 2, 3, 4);
    for (int c = 1; c <= TO; c++) begin
      chk("t3_busy", 64'(busy), 64'd1);
      cyc();
    end
    chk("t3_err", 64'(err), 64'd1);
    chk("t3_code", 64'(code), 64'd3);
    chk("t3_done", 64'(done), 64'd0);
    chk("t3_ready", 64'(ready), 64'd1);

    // Valid arriving in the last fetch cycle wins over timeout
    push(0, 0, 2, 4, 16'h5A5A);
    req(1, 2, 3, 4);
    repeat (TO - 1) cyc();
    set_unit(1, 1'b1, 16'h5A5A);
    cyc();
    chk("t3b_dlv_valid", 64'(o_unit_valid), 64'b0100);
    chk("t3b_dlv_data", 64'(o_unit_data), 64'h5A5A);
    set_unit(1, 1'b0, 16'h0);
    cyc();
    chk("t3b_done", 64'(done), 64'd1);
    chk("t3b_err", 64'(err), 64'd0);

    // Rejected requests
    cyc();
    chk("t4_ready_pre", 64'(ready), 64'd1);
    push(1, 1, 0, 0, 16'h0);
    req(7, 0, 1, 1);
    chk("t4_bad_err", 64'(err), 64'd1);
    chk("t4_bad_code", 64'(code), 64'd1);
    chk("t4_bad_cmd", 64'(o_unit_cmd), 64'd0);
    chk("t4_bad_ready", 64'(ready), 64'd1);
    cyc();
    chk("t4_err_pulse", 64'(err), 64'd0);
    chk("t4_code_hold", 64'(code), 64'd1);
    push(1, 1, 0, 0, 16'h0);
    req(6, 6, 1, 1);
    chk("t4_both_code", 64'(code), 64'd1);
    push(1, 2, 0, 0, 16'h0);
    req(2, 2, 1, 1);
    chk("t4_same_err", 64'(err), 64'd1);
    chk("t4_same_code", 64'(code), 64'd2);
    chk("t4_same_ready", 64'(ready), 64'd1);
    cyc();

    // Back-to-back: second request presented in the done cycle
    set_unit(0, 1'b1, 16'hAAAA);
    set_unit(3, 1'b1, 16'h5555);
    push(0, 0, 1, 6, 16'hAAAA);
    req(0, 1, 7, 6);
    cyc();
    cyc();
    chk("t5_done1", 64'(done), 64'd1);
    push(0, 0, 2, 8, 16'h5555);
    req(3, 2, 7, 8);
    chk("t5_accepted", 64'(busy), 64'd1);
    chk("t5_no_early_done", 64'(done), 64'd0);
    cyc();
    cyc();
    chk("t5_done2", 64'(done), 64'd1);
    set_unit(0, 1'b0, 16'h0);
    set_unit(3, 1'b0, 16'h0);
    cyc();

    // Asynchronous reset in the middle of FETCH
    req(1, 3, 2, 2);
    cyc();
    #2 rst = 1'b1;
    #1;
    chk("t6_async_outputs", 64'({ready, busy, done, err, code, o_unit_cmd, o_unit_valid, o_unit_data}), 64'd0);
    cyc();
    cyc();
    chk("t6_no_pulse", 64'({done, err}), 64'd0);
    rst = 1'b0;
    cyc();
    chk("t6_ready", 64'(ready), 64'd1);
    chk("t6_idle", 64'(busy), 64'd0);
    set_unit(0, 1'b1, 16'h00FF);
    push(0, 0, 1, 3, 16'h00FF);
    req(0, 1, 4, 3);
    w = 0;
    while (!done && w < 10) begin
      cyc();
      w++;
    end
    chk("t6_done_seen", 64'(done), 64'd1);
    chk("t6_latency", 64'(w), 64'd2);
    set_unit(0, 1'b0, 16'h0);
    cyc();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
